// File: rtl/adder_rr_arbiter.sv
// Round-robin front end that time-shares one external combinational adder among NUM_REQ requesters.
// Optional build macro ADDER_ARB_OVF_EN adds a registered signed-overflow flag on the response (rsp_ovf).
module adder_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 64,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_cin,
  input  logic [WIDTH-1:0]         add_sum,
  input  logic                     add_cout,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic [ID_W-1:0]          rsp_id
`ifdef ADDER_ARB_OVF_EN
  ,
  output logic                     rsp_ovf
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]         state_q,    state_d;
  logic [ID_W-1:0]    rr_ptr_q,   rr_ptr_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [WIDTH-1:0]   add_a_q,    add_a_d;
  logic [WIDTH-1:0]   add_b_q,    add_b_d;
  logic               add_cin_q,  add_cin_d;
  logic [WIDTH-1:0]   rsp_sum_q,  rsp_sum_d;
  logic               rsp_cout_q, rsp_cout_d;
  logic [ID_W-1:0]    rsp_id_q,   rsp_id_d;
  logic               rsp_valid_q, rsp_valid_d;

  logic [ID_W:0]      pick_s;
  logic               found_s;
  logic [ID_W-1:0]    sel_s;
  logic [NUM_REQ-1:0] grant_oh_s;
  logic [WIDTH-1:0]   sel_a_s;
  logic [WIDTH-1:0]   sel_b_s;
  logic               sel_cin_s;

  // Walking offsets from the highest down lets the nearest valid requester at or after ptr win.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] vld, input logic [ID_W-1:0] ptr);
    logic [ID_W:0] res;
    res = {(ID_W+1){1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (vld[i] && (((int'(ptr) + k) % NUM_REQ) == i)) begin
          res = {1'b1, ID_W'(i)};
        end else begin
          res = res;
        end
      end
    end
    return res;
  endfunction

  assign pick_s  = rr_pick(req_valid, rr_ptr_q);
  assign found_s = pick_s[ID_W];
  assign sel_s   = pick_s[ID_W-1:0];

  // One-hot grant and AND-OR operand selection for the winning requester.
  always_comb begin
    grant_oh_s = {NUM_REQ{1'b0}};
    sel_a_s    = {WIDTH{1'b0}};
    sel_b_s    = {WIDTH{1'b0}};
    sel_cin_s  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_oh_s[i] = found_s & (sel_s == ID_W'(i));
      sel_a_s       = sel_a_s | (req_a[i*WIDTH +: WIDTH] & {WIDTH{grant_oh_s[i]}});
      sel_b_s       = sel_b_s | (req_b[i*WIDTH +: WIDTH] & {WIDTH{grant_oh_s[i]}});
      sel_cin_s     = sel_cin_s | (req_cin[i] & grant_oh_s[i]);
    end
  end

  assign req_ready = ((state_q == ST_IDLE) && !rst) ? grant_oh_s : {NUM_REQ{1'b0}};

  // Next-state logic for the IDLE -> CALC -> RESP cycle.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_cin_d   = add_cin_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          add_a_d    = sel_a_s;
          add_b_d    = sel_b_s;
          add_cin_d  = sel_cin_s;
          grant_id_d = sel_s;
          state_d    = ST_CALC;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_CALC: begin
        rsp_sum_d   = add_sum;
        rsp_cout_d  = add_cout;
        rsp_id_d    = grant_id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = (grant_id_q == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : grant_id_q + ID_W'(1);
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= {ID_W{1'b0}};
      grant_id_q  <= {ID_W{1'b0}};
      add_a_q     <= {WIDTH{1'b0}};
      add_b_q     <= {WIDTH{1'b0}};
      add_cin_q   <= 1'b0;
      rsp_sum_q   <= {WIDTH{1'b0}};
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= {ID_W{1'b0}};
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_valid = rsp_valid_q;

`ifdef ADDER_ARB_OVF_EN
  logic rsp_ovf_q, rsp_ovf_d;

  // Like-signed operands whose sum flips sign have overflowed; captured alongside rsp_sum.
  always_comb begin
    if (state_q == ST_CALC) begin
      rsp_ovf_d = (add_a_q[WIDTH-1] == add_b_q[WIDTH-1]) & (add_sum[WIDTH-1] != add_a_q[WIDTH-1]);
    end else begin
      rsp_ovf_d = rsp_ovf_q;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_ovf_q <= 1'b0;
    end else begin
      rsp_ovf_q <= rsp_ovf_d;
    end
  end

  assign rsp_ovf = rsp_ovf_q;
`else
`endif

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed self-checking bench for adder_rr_arbiter with a behavioural stand-in for the shared adder.
module tb_adder_rr_arbiter;
  localparam int N = 4;
  localparam int W = 64;
  localparam int IW = 2;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N-1:0]     req_cin;
  logic [W-1:0]     add_a;
  logic [W-1:0]     add_b;
  logic             add_cin;
  logic [W-1:0]     add_sum;
  logic             add_cout;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_sum;
  logic             rsp_cout;
  logic [IW-1:0]    rsp_id;
`ifdef ADDER_ARB_OVF_EN
  logic             rsp_ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  adder_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id)
`ifdef ADDER_ARB_OVF_EN
    , .rsp_ovf(rsp_ovf)
`endif
  );

  // Stand-in for the external carry-select adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Single-requester transaction from IDLE; ends back in IDLE one cycle after the response handshake.
  task automatic do_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic [W-1:0] es, input logic ec, input logic eovf);
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_cin[id] = cin;
    #1;
    check("op_req_ready", req_ready, 4'b0001 << id);
    @(posedge clk); #1;
    req_valid = '0;
    check("op_calc_valid", rsp_valid, 1'b0);
    check("op_add_a", add_a, a);
    check("op_calc_ready", req_ready, 4'b0000);
    @(posedge clk); #1;
    check("op_rsp_valid", rsp_valid, 1'b1);
    check("op_rsp_sum", rsp_sum, es);
    check("op_rsp_cout", rsp_cout, ec);
    check("op_rsp_id", rsp_id, id);
`ifdef ADDER_ARB_OVF_EN
    check("op_rsp_ovf", rsp_ovf, eovf);
`else
    if (eovf === 1'bx) $display("unexpected X overflow argument");
`endif
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("op_rsp_done", rsp_valid, 1'b0);
    check("op_add_hold", add_b, b);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] exp_sum;
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_cin = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'b0001;
    #1;
    check("rst_ready", req_ready, 4'b0000);
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_add_a", add_a, 64'h0);
    check("rst_sum", rsp_sum, 64'h0);
    check("rst_id", rsp_id, 2'd0);
    req_valid = '0;
    rst = 1'b0;

    do_op(0, 64'h3, 64'h5, 1'b0, 64'h8, 1'b0, 1'b0);
    do_op(2, 64'h3, 64'h5, 1'b1, 64'h9, 1'b0, 1'b0);
    do_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    do_op(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0,
          64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1);

    // Round robin from a fresh reset with everyone valid and the consumer always ready.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 64'h1000 * (i + 1);
      req_b[i*W +: W] = 64'(i);
      req_cin[i] = i[0];
    end
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int n = 0; n < 8; n++) begin
      int e;
      e = n % 4;
      exp_sum = 64'h1000 * (e + 1) + 64'(e) + 64'(e % 2);
      check("rr_grant", req_ready, 4'b0001 << e);
      @(posedge clk); #1;
      check("rr_calc_ready", req_ready, 4'b0000);
      check("rr_calc_valid", rsp_valid, 1'b0);
      @(posedge clk); #1;
      check("rr_rsp_valid", rsp_valid, 1'b1);
      check("rr_rsp_id", rsp_id, e);
      check("rr_rsp_sum", rsp_sum, exp_sum);
      @(posedge clk); #1;
    end

    // Backpressure: requester 0 wins, its result is held while the consumer stalls.
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("bp_valid", rsp_valid, 1'b1);
    check("bp_id", rsp_id, 2'd0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", rsp_valid, 1'b1);
      check("bp_hold_sum", rsp_sum, 64'h1000);
      check("bp_hold_id", rsp_id, 2'd0);
      check("bp_hold_ready", req_ready, 4'b0000);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("bp_released", rsp_valid, 1'b0);
    check("bp_next_grant", req_ready, 4'b0010);

    // Requester 2 is granted, then reset hits while the block is in CALC.
    req_valid = 4'b0100;
    #1;
    check("pre_rst_grant", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("calc_rst_valid", rsp_valid, 1'b0);
    check("calc_rst_add_a", add_a, 64'h0);
    @(posedge clk); #1;
    check("calc_rst_no_rsp", rsp_valid, 1'b0);
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    #1;
    check("calc_rst_ptr", req_ready, 4'b0001);
    req_valid = '0;
    do_op(3, 64'h1234, 64'h1111, 1'b1, 64'h2346, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
- Shares one combinational 64-bit carry-select adder (CSA2_64bit, instantiated by the parent) among NUM_REQ requesters.
- Round-robin arbitration; operands are latched and driven to the adder, and the sum/carry are captured.
- One result is returned at a time on a valid/ready response channel, tagged with the requester id.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 64, operand/sum width; must match the adder instance.
- ID_W, 2, requester id width; must be at least clog2(NUM_REQ).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*WIDTH  packed operand A; requester i occupies [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  packed operand B, same packing.
- req_cin  input  NUM_REQ  per-requester carry-in.
- add_a  output  WIDTH  to adder a.
- add_b  output  WIDTH  to adder b.
- add_cin  output  1  to adder c_in.
- add_sum  input  WIDTH  from adder sum.
- add_cout  input  1  from adder c_out.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accept.
- rsp_sum  output  WIDTH  captured sum.
- rsp_cout  output  1  captured carry-out.
- rsp_id  output  ID_W  index of the requester that produced this result.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, rr_ptr=0.
  - add_a, add_b, add_cin, rsp_sum, rsp_cout, rsp_id and rsp_valid all 0.
  - req_ready is 0 while rst=1.
  - Reset mid-operation aborts any latched or pending result without emitting it.
- States:
  - IDLE: select the first i with req_valid[i]=1, searching from rr_ptr upward with modulo-NUM_REQ wrap.
  - IDLE: req_ready[sel]=1 combinationally in the same cycle; all other req_ready bits 0.
  - IDLE: on handshake (req_valid & req_ready), latch req_a/req_b/req_cin of sel into add_a/add_b/add_cin, latch sel into grant_id, and go to CALC.
  - IDLE: with no valid request, stay in IDLE with all req_ready bits 0.
  - CALC: one settle cycle; add_* held stable. At the clock edge, capture add_sum to rsp_sum, add_cout to rsp_cout and grant_id to rsp_id; set rsp_valid=1; go to RESP.
  - RESP: rsp_valid=1 and the rsp_* outputs are held stable until rsp_valid & rsp_ready.
  - RESP: on that handshake, rsp_valid goes to 0, rr_ptr = (grant_id+1) mod NUM_REQ, and state returns to IDLE.
  - req_ready is 0 in CALC and RESP.
- Latency and throughput:
  - Request handshake to rsp_valid: 2 clock edges.
  - Peak throughput is 1 operation per 3 cycles when rsp_ready is held at 1.
- Fairness: a requester that has just been served has lowest priority on the next arbitration.
  - With all requesters continuously valid, grants cycle 0,1,2,3,0,...
- Arithmetic: {rsp_cout, rsp_sum} = a + b + cin, modulo 2^(WIDTH+1), as computed by the external adder. The block performs no arithmetic of its own.
- Request semantics:
  - A requester may drop req_valid before it is granted; no state is affected.
  - Operands are sampled only at the handshake edge.
- Simultaneous events: rsp_ready asserted in CALC has no effect; a result is never consumed in the cycle it is captured.
- add_a, add_b and add_cin keep their last values while the block is idle.

Optional Feature:
- Macro: ADDER_ARB_OVF_EN.
- When defined:
  - Adds output rsp_ovf (1 bit), the signed two's-complement overflow flag, captured in CALC together with rsp_sum.
  - rsp_ovf = (add_a[WIDTH-1] == add_b[WIDTH-1]) & (add_sum[WIDTH-1] != add_a[WIDTH-1]).
  - rsp_ovf resets to 0.
- When undefined: the port does not exist and behaviour is otherwise identical.

Test Plan:
- Requester 0 only, a=0x3, b=0x5, cin=0 -> rsp_sum=0x8, rsp_cout=0, rsp_id=0, rsp_valid 2 edges after the handshake.
- Requester 2 only, a=0x3, b=0x5, cin=1 -> rsp_sum=0x9, rsp_cout=0, rsp_id=2.
- Requester 1 only, a=b=0xFFFFFFFFFFFFFFFF, cin=1 -> rsp_sum=0xFFFFFFFFFFFFFFFF, rsp_cout=1, rsp_id=1.
  - With ADDER_ARB_OVF_EN: rsp_ovf=0.
  - Also a=b=0x7FFFFFFFFFFFFFFF, cin=0 -> rsp_sum=0xFFFFFFFFFFFFFFFE, rsp_ovf=1.
- All 4 requesters held valid and rsp_ready=1 for 8 operations -> rsp_id sequence 0,1,2,3,0,1,2,3; a request is accepted every 3rd cycle.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_* stable, req_ready stays all-zero; after rsp_ready=1, the next grant goes to (id+1) mod 4.
- Assert rst for 1 cycle while in CALC -> next cycle rsp_valid=0, state IDLE, rr_ptr=0, no result emitted; a new request from requester 3 is then accepted and returned with rsp_id=3.
